// File: rtl/pll_freq_checker.sv
// pll_freq_checker
//   Measures PLL output taps against per-channel expected edge counts.
//   Tap bits are synchronised into CLK. Their rising edges are then counted
//   over a fixed gate window while the PLL is locked. Each count is compared
//   against an inclusive [EXP_MIN, EXP_MAX] range.
//
// Build option: define PLL_FREQ_CHECKER_STICKY_FAIL_EN to make O_FAIL a set of
//   sticky flags. These are cleared only by RST. Without it, O_FAIL mirrors
//   ~O_PASS once a first result has been seen.
//
// Ports:
//   CLK         system clock
//   RST         synchronous reset, active-high
//   I_LOCKED    PLL lock indication (asynchronous)
//   I_TAP       divided PLL clock bits, one per channel (asynchronous)
//   I_SEL       channel whose latched count drives O_COUNT
//   O_VALID     one-cycle pulse when a new set of results is latched
//   O_PASS      per-channel in-range result of the last window
//   O_FAIL      per-channel failure flags
//   O_LOCK_LOST sticky: lock dropped while a window was running
//   O_COUNT     latched edge count of channel I_SEL (0 if out of range)
module pll_freq_checker #(
  parameter int unsigned                   CHANNELS      = 6,
  parameter int unsigned                   CNT_WIDTH     = 16,
  parameter int unsigned                   GATE_CYCLES   = 65536,
  parameter int unsigned                   SETTLE_CYCLES = 1024,
  parameter logic [CHANNELS*CNT_WIDTH-1:0] EXP_MIN       = '0,
  parameter logic [CHANNELS*CNT_WIDTH-1:0] EXP_MAX       = '1
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic                                           I_LOCKED,
  input  logic [CHANNELS-1:0]                            I_TAP,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] I_SEL,
  output logic                                           O_VALID,
  output logic [CHANNELS-1:0]                            O_PASS,
  output logic [CHANNELS-1:0]                            O_FAIL,
  output logic                                           O_LOCK_LOST,
  output logic [CNT_WIDTH-1:0]                           O_COUNT
);

  localparam int unsigned TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, EVAL} state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic                   lock_s1, lock_s2;
  logic [CHANNELS-1:0]    tap_s1, tap_s2, tap_prev;
  logic [CHANNELS-1:0]    tap_rise;
  logic [CNT_WIDTH-1:0]   cnt     [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_inc [CHANNELS];
  logic [CNT_WIDTH-1:0]   lat     [CHANNELS];
  logic [CHANNELS-1:0]    in_range;
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
  logic [CHANNELS-1:0]    fail_r;
`else
  logic                   seen;
`endif

  // Two synchroniser flops plus one history flop for tap edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
      tap_s1   <= '0;
      tap_s2   <= '0;
      tap_prev <= '0;
    end else begin
      lock_s1  <= I_LOCKED;
      lock_s2  <= lock_s1;
      tap_s1   <= I_TAP;
      tap_s2   <= tap_s1;
      tap_prev <= tap_s2;
    end
  end

  assign tap_rise = tap_s2 & ~tap_prev;

  // Saturating next count and range check on that next value, so that
  // an edge seen in the final gate cycle is included in the result.
  always_comb begin
    in_range = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_inc[i] = cnt[i];
      if (tap_rise[i] && (cnt[i] != '1))
        cnt_inc[i] = cnt[i] + CNT_WIDTH'(1);
      in_range[i] = (cnt_inc[i] >= EXP_MIN[i*CNT_WIDTH +: CNT_WIDTH]) &&
                    (cnt_inc[i] <= EXP_MAX[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  // Results are latched on the last GATE cycle. O_VALID is therefore high
  // during the EVAL cycle. EVAL itself only clears counters and drops edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      timer       <= '0;
      O_VALID     <= 1'b0;
      O_PASS      <= '0;
      O_LOCK_LOST <= 1'b0;
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
      fail_r      <= '0;
`else
      seen        <= 1'b0;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        lat[i] <= '0;
      end
    end else begin
      O_VALID <= 1'b0;
      case (state)
        IDLE: begin
          timer <= TW'(SETTLE_CYCLES - 1);
          for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
          if (lock_s2) state <= SETTLE;
        end

        SETTLE: begin
          if (!lock_s2) begin
            state <= IDLE;
          end else if (timer == '0) begin
            state <= GATE;
            timer <= TW'(GATE_CYCLES - 1);
          end else begin
            timer <= timer - TW'(1);
          end
        end

        GATE: begin
          if (!lock_s2) begin
            state       <= IDLE;
            O_LOCK_LOST <= 1'b1;
            O_PASS      <= '0;
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
            fail_r      <= '1;
`else
            seen        <= 1'b0;
`endif
            for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
          end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= cnt_inc[i];
            if (timer == '0) begin
              state   <= EVAL;
              O_VALID <= 1'b1;
              O_PASS  <= in_range;
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
              fail_r  <= fail_r | ~in_range;
`else
              seen    <= 1'b1;
`endif
              for (int unsigned i = 0; i < CHANNELS; i++) lat[i] <= cnt_inc[i];
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end

        EVAL: begin
          timer <= TW'(GATE_CYCLES - 1);
          for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
          if (!lock_s2) begin
            state       <= IDLE;
            O_LOCK_LOST <= 1'b1;
          end else begin
            state <= GATE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
  assign O_FAIL = fail_r;
`else
  assign O_FAIL = ~O_PASS & {CHANNELS{seen}};
`endif

  always_comb begin
    O_COUNT = '0;
    if (32'(I_SEL) < CHANNELS) O_COUNT = lat[I_SEL];
  end

endmodule

// File: tb/tb_pll_freq_checker.sv
module tb_pll_freq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic        tap0 = 1'b0, tap1 = 1'b0, tap2 = 1'b0;
  logic        sel, sel2;
  logic        valid, lost, valid2, lost2;
  logic [1:0]  pass, fail, pass2, fail2;
  logic [15:0] count;
  logic [3:0]  count2;

  int unsigned hp0 = 5, hp1 = 10, hp2 = 2;
  int unsigned c0 = 0, c1 = 0, c2 = 0;
  int unsigned checks = 0, failures = 0;
  int unsigned n;
  logic [1:0]  exp_fail_sticky;

  always #5 clk = ~clk;

  // Free-running taps, half-period given in CLK cycles
  always @(negedge clk) begin
    if (c0 + 1 >= hp0) begin c0 = 0; tap0 = ~tap0; end else c0 = c0 + 1;
    if (c1 + 1 >= hp1) begin c1 = 0; tap1 = ~tap1; end else c1 = c1 + 1;
    if (c2 + 1 >= hp2) begin c2 = 0; tap2 = ~tap2; end else c2 = c2 + 1;
  end

  pll_freq_checker #(
    .CHANNELS      (2),
    .CNT_WIDTH     (16),
    .GATE_CYCLES   (1000),
    .SETTLE_CYCLES (16),
    .EXP_MIN       ({16'd49, 16'd99}),
    .EXP_MAX       ({16'd51, 16'd101})
  ) dut (
    .CLK (clk), .RST (rst), .I_LOCKED (locked), .I_TAP ({tap1, tap0}),
    .I_SEL (sel), .O_VALID (valid), .O_PASS (pass), .O_FAIL (fail),
    .O_LOCK_LOST (lost), .O_COUNT (count)
  );

  pll_freq_checker #(
    .CHANNELS      (2),
    .CNT_WIDTH     (4),
    .GATE_CYCLES   (1000),
    .SETTLE_CYCLES (16),
    .EXP_MIN       ({4'd0, 4'd15}),
    .EXP_MAX       ({4'd15, 4'd15})
  ) dut_sat (
    .CLK (clk), .RST (rst), .I_LOCKED (locked), .I_TAP ({1'b0, tap2}),
    .I_SEL (sel2), .O_VALID (valid2), .O_PASS (pass2), .O_FAIL (fail2),
    .O_LOCK_LOST (lost2), .O_COUNT (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the number of rising edges until O_VALID is seen, 0 on timeout
  task automatic wait_valid(output int unsigned cycles);
    cycles = 0;
    for (int i = 1; i <= 3000 && cycles == 0; i++) begin
      @(posedge clk); #1;
      if (valid) cycles = i;
    end
  endtask

  initial begin
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
    exp_fail_sticky = 2'b10;
`else
    exp_fail_sticky = 2'b00;
`endif
    rst = 1'b1; locked = 1'b0; sel = 1'b0; sel2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_pass",  pass,  0);
    check("rst_fail",  fail,  0);
    check("rst_lost",  lost,  0);
    check("rst_count", count, 0);

    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    locked = 1'b1;
    wait_valid(n);
    check("first_valid_lat", n, 1019);
    check("first_pass", pass, 2'b11);
    check("first_fail", fail, 2'b00);
    check("sat_valid",  valid2, 1);
    check("sat_pass",   pass2, 2'b11);
    sel = 1'b0; sel2 = 1'b0; #1;
    check("count0", count, 100);
    check("sat_count0", count2, 15);
    sel = 1'b1; sel2 = 1'b1; #1;
    check("count1", count, 50);
    check("sat_count1", count2, 0);

    wait_valid(n);
    check("valid_period", n, 1001);
    @(posedge clk); #1;
    check("valid_pulse_end", valid, 0);

    // tap1 too fast: period 8 -> 125 edges per window
    hp1 = 4;
    wait_valid(n);
    wait_valid(n);
    sel = 1'b1; #1;
    check("fast_count1", count, 125);
    check("fast_pass", pass, 2'b01);
    check("fast_fail", fail, 2'b10);

    hp1 = 10;
    wait_valid(n);
    wait_valid(n);
    #1;
    check("restored_count1", count, 50);
    check("restored_pass", pass, 2'b11);
    check("restored_fail", fail, exp_fail_sticky);

    // lock loss in the middle of a gate window
    repeat (500) @(posedge clk);
    @(negedge clk) locked = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drop_lost", lost, 1);
    check("drop_pass", pass, 0);
`ifdef PLL_FREQ_CHECKER_STICKY_FAIL_EN
    check("drop_fail", fail, 2'b11);
`else
    check("drop_fail", fail, 2'b00);
`endif
    repeat (15) @(negedge clk);
    locked = 1'b1;
    wait_valid(n);
    check("relock_lat", n, 1019);
    check("relock_pass", pass, 2'b11);
    check("relock_lost_held", lost, 1);
    sel = 1'b0; #1;
    check("relock_count0", count, 100);

    // reset in the middle of a gate window
    repeat (300) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", valid, 0);
    check("midrst_pass",  pass,  0);
    check("midrst_fail",  fail,  0);
    check("midrst_lost",  lost,  0);
    check("midrst_count", count, 0);
    @(negedge clk) rst = 1'b0;
    wait_valid(n);
    check("postrst_lat", n, 1019);

    // lock glitch while settling
    @(negedge clk) begin locked = 1'b0; rst = 1'b1; end
    repeat (2) @(negedge clk);
    rst = 1'b0; locked = 1'b1;
    repeat (8) @(negedge clk);
    locked = 1'b0;
    repeat (3) @(negedge clk);
    locked = 1'b1;
    wait_valid(n);
    check("glitch_lat", n, 1019);
    check("glitch_lost", lost, 0);
    check("glitch_pass", pass, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_freq_checker.md
# pll_freq_checker

Frequency checker for PLL output taps in hardware tests. It takes toggling bits from counters clocked by PLL outputs, synchronises them into the `CLK` domain and counts their rising edges over a fixed gate window, but only while the PLL reports lock. Each count is compared against a per-channel expected range and the pass/fail result is driven to board LEDs. It sits beside the PLL tester in board tops and replaces visual LED-blink checking with a deterministic verdict.

## Interface
Parameters:
- `CHANNELS`, default 6: number of tap inputs.
- `CNT_WIDTH`, default 16: edge counter width per channel.
- `GATE_CYCLES`, default 65536: gate window length in `CLK` cycles (≥ 2).
- `SETTLE_CYCLES`, default 1024: lock-stable wait before the first window (≥ 1).
- `EXP_MIN`, default all-zero: `CHANNELS*CNT_WIDTH` flattened vector, inclusive lower bound; channel i sits at bits [i*CNT_WIDTH +: CNT_WIDTH].
- `EXP_MAX`, default all-ones: same layout, inclusive upper bound.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: synchronous reset, active-high.
- `I_LOCKED` in 1: PLL LOCKED, asynchronous to `CLK`.
- `I_TAP` in CHANNELS: divided PLL clock bits, asynchronous to `CLK`.
- `I_SEL` in $clog2(CHANNELS): channel selected for count readout.
- `O_VALID` out 1: one-cycle pulse when new results are latched.
- `O_PASS` out CHANNELS: per-channel result of the last window.
- `O_FAIL` out CHANNELS: failure flags (see Configuration).
- `O_LOCK_LOST` out 1: sticky flag, lock dropped after a window started.
- `O_COUNT` out CNT_WIDTH: latched count of channel `I_SEL`.

## Operation
- Synchroniser: `I_LOCKED` and each `I_TAP` bit pass through a 2-flop synchroniser. A third flop provides edge detection: edge = sync & ~prev.
- FSM states: IDLE, SETTLE, GATE, EVAL.
  - IDLE: waits for synced lock = 1, then goes to SETTLE and loads the settle counter.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then goes to GATE. Lock = 0 returns to IDLE and does not set `O_LOCK_LOST`.
  - GATE: counts edges per channel for exactly `GATE_CYCLES` cycles, then goes to EVAL. Lock = 0 goes to IDLE, sets `O_LOCK_LOST`, clears `O_PASS` and discards partial counts.
  - EVAL: lasts one cycle.
    - Latches all counts.
    - Sets `O_PASS[i] = EXP_MIN_i ≤ cnt_i ≤ EXP_MAX_i`.
    - Pulses `O_VALID`.
    - Clears the edge counters and returns to GATE.
    - Edges detected during EVAL are dropped.
    - If lock = 0 during EVAL, results are still latched, then the FSM goes to IDLE and sets `O_LOCK_LOST`.
- Edge counters saturate at 2^CNT_WIDTH−1 and never wrap. A saturated count compares normally.
- `O_COUNT` is combinational from the latched counts, indexed by `I_SEL`. An out-of-range `I_SEL` returns 0.
- Tap toggle rate must be below `CLK`/2. Faster taps alias; this is not detected.

## Timing
- Reset values:
  - FSM = IDLE.
  - All counters = 0.
  - `O_VALID` = 0, `O_PASS` = 0, `O_FAIL` = 0, `O_LOCK_LOST` = 0.
  - Latched counts = 0, so `O_COUNT` = 0.
  - Synchroniser flops = 0.
- `RST` mid-window aborts immediately. The next cycle behaves as post-reset.
- `I_LOCKED` rising → FSM leaves IDLE 3 cycles later (2 synchroniser cycles + 1 register).
- First `O_VALID` comes 3 + `SETTLE_CYCLES` + `GATE_CYCLES` cycles after lock rises. After that, `O_VALID` repeats every `GATE_CYCLES`+1 cycles.
- Tap edge latency is 3 cycles. Edges within 3 cycles of the window boundary may count in either window (±1 tolerance; bounds must allow for it).
- `O_PASS` and `O_COUNT` change only on the `O_VALID` cycle, or on the lock-loss clear.

## Configuration
- `PLL_FREQ_CHECKER_STICKY_FAIL_EN` defined:
  - `O_FAIL[i]` is a sticky register, set in EVAL when channel i is out of range, and also set for all channels on lock loss during GATE.
  - It clears only on `RST`.
- Not defined:
  - `O_FAIL = ~O_PASS & {CHANNELS{seen}}`, where `seen` is a 1-bit register set by the first `O_VALID` and cleared by `RST` or lock loss.
  - No sticky storage.

## Test plan
- Setup: `GATE_CYCLES`=1000, `SETTLE_CYCLES`=16, `CHANNELS`=2. Lock high; tap0 period 10 `CLK`; tap1 period 20; `EXP` = [99..101] and [49..51]. Required: `O_VALID` at cycle 1019 after lock; `O_PASS`=2'b11; `O_COUNT` = 100 and 50.
- tap1 period 8, same bounds → `O_PASS`=2'b01, `O_FAIL[1]`=1. After tap1 is restored: sticky build keeps `O_FAIL[1]`=1; non-sticky build clears it.
- Lock dropped at cycle 500 of GATE → `O_LOCK_LOST`=1, `O_PASS`=0, no `O_VALID`. Lock restored → new window after settle.
- Lock glitch during SETTLE → return to IDLE, `O_LOCK_LOST` stays 0.
- `CNT_WIDTH`=4 with tap period 4 over 1000 cycles → count saturates at 15, not wrapped.
- `RST` asserted mid-GATE → all outputs 0 next cycle; a full settle + gate window is required before the next `O_VALID`.
